// File: rtl/fft_arb_pkg.sv
// Shared types and constants for the FFT input stream arbiter.
// Holds the FSM state encoding, default sizing and the round-robin search.
package fft_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int DEF_N         = 4;
    localparam int DEF_W         = 16;
    localparam int DEF_FRAME_LEN = 1024;
    localparam int RR_MAX        = 16;

    // First requester strictly after ptr (wrapping modulo n); returns ptr if none.
    function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        int         cand;
        logic [3:0] idx;
        rr_pick = ptr;
        for (int i = RR_MAX; i >= 1; i--) begin
            if (i <= n) begin
                cand = (ptr + i) % n;
                idx  = 4'(cand);
                if (req[idx]) begin
                    rr_pick = cand;
                end else begin
                    rr_pick = rr_pick;
                end
            end else begin
                cand = ptr;
            end
        end
    endfunction

endpackage

// File: rtl/fft_arb_skid.sv
// Two-entry ping-pong register skid buffer with valid/ready on both sides.
// Accepts while fewer than two entries are held; output is the oldest entry.
module fft_arb_skid #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [PW-1:0] in_payload,
    output logic          in_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_payload,
    input  logic          out_ready
);

    logic [1:0][PW-1:0] slot_r;
    logic               wr_sel_r;
    logic               rd_sel_r;
    logic [1:0]         count_r;
    logic               push_s;
    logic               pop_s;

    assign in_ready    = (count_r != 2'd2);
    assign out_valid   = (count_r != 2'd0);
    assign out_payload = slot_r[rd_sel_r];
    assign push_s      = in_valid & in_ready;
    assign pop_s       = out_valid & out_ready;

    // Slot storage and ping-pong write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r   <= '0;
            wr_sel_r <= 1'b0;
        end else if (push_s) begin
            slot_r[wr_sel_r] <= in_payload;
            wr_sel_r         <= ~wr_sel_r;
        end else begin
            wr_sel_r <= wr_sel_r;
        end
    end

    // Read pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (pop_s) begin
                rd_sel_r <= ~rd_sel_r;
            end else begin
                rd_sel_r <= rd_sel_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fft_stream_arbiter.sv
// Frame-granular round-robin arbiter feeding one FFT input stream via a skid buffer.
// Optional build macro FFT_ARB_FRAME_CNT_EN caps each grant at FRAME_LEN beats.
module fft_stream_arbiter
    import fft_arb_pkg::*;
#(
    parameter  int N         = DEF_N,
    parameter  int W         = DEF_W,
    parameter  int FRAME_LEN = DEF_FRAME_LEN,
    localparam int CW        = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [CW-1:0]  out_chan,
    input  logic           out_ready,
    output logic           busy
);

    localparam int PW = W + 1 + CW;

    if (N < 2 || N > RR_MAX || FRAME_LEN < 1) begin : g_bad_cfg
        $error("fft_stream_arbiter: unsupported N or FRAME_LEN");
    end

    arb_state_e         state_r;
    arb_state_e         state_s;
    logic [CW-1:0]      grant_r;
    logic [CW-1:0]      grant_s;
    logic [CW-1:0]      rr_ptr_r;
    logic [CW-1:0]      rr_ptr_s;
    logic               busy_r;
    logic [RR_MAX-1:0]  req_s;
    logic               skid_in_valid_s;
    logic               skid_in_ready_s;
    logic [PW-1:0]      skid_out_payload_s;
    logic               accept_s;
    logic               beat_last_s;
    logic               end_s;
    logic [W-1:0]       beat_data_s;

    assign beat_data_s     = in_data[int'(grant_r)*W +: W];
    assign beat_last_s     = in_last[grant_r];
    assign skid_in_valid_s = (state_r == XFER) & in_valid[grant_r];
    assign accept_s        = skid_in_valid_s & skid_in_ready_s;
    assign busy            = busy_r;

`ifdef FFT_ARB_FRAME_CNT_EN
    localparam int CNTW = $clog2(FRAME_LEN + 1);
    logic [CNTW-1:0] beat_cnt_r;
    logic            cnt_hit_s;

    assign cnt_hit_s = (beat_cnt_r == CNTW'(FRAME_LEN - 1));
    assign end_s     = beat_last_s | cnt_hit_s;

    // Beats accepted under the current grant; cleared whenever no grant is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= '0;
        end else if (state_r == IDLE) begin
            beat_cnt_r <= '0;
        end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + CNTW'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end
`else
    assign end_s = beat_last_s;
`endif

    // Widen the request vector to the fixed width the search function expects.
    always_comb begin
        req_s        = '0;
        req_s[N-1:0] = in_valid;
    end

    // Only the held grant may see the skid's ready.
    always_comb begin
        in_ready = '0;
        if (state_r == XFER) begin
            in_ready[grant_r] = skid_in_ready_s;
        end else begin
            in_ready = '0;
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until the frame ends.
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        rr_ptr_s = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (|in_valid) begin
                    grant_s = CW'(rr_pick(req_s, int'(rr_ptr_r), N));
                    state_s = XFER;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (accept_s && end_s) begin
                    rr_ptr_s = grant_r;
                    state_s  = IDLE;
                end else begin
                    state_s = XFER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            rr_ptr_r <= CW'(N - 1);
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            rr_ptr_r <= rr_ptr_s;
            busy_r   <= (state_s == XFER);
        end
    end

    fft_arb_skid #(
        .PW (PW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (skid_in_valid_s),
        .in_payload  ({end_s, grant_r, beat_data_s}),
        .in_ready    (skid_in_ready_s),
        .out_valid   (out_valid),
        .out_payload (skid_out_payload_s),
        .out_ready   (out_ready)
    );

    assign {out_last, out_chan, out_data} = skid_out_payload_s;

endmodule

// File: tb/tb_fft_stream_arbiter.sv
// Self-checking bench for fft_stream_arbiter: randomized and directed sources
// checked every cycle against a queue/owner-level reference model.
module tb_fft_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 2;
`ifdef FFT_ARB_FRAME_CNT_EN
    localparam int FLEN = 8;
`else
    localparam int FLEN = 0;
`endif

    typedef struct packed {
        logic          last;
        logic [CW-1:0] chan;
        logic [W-1:0]  data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [CW-1:0]  out_chan;
    logic           out_ready;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W:0]   src_q [N][$];
    logic [N-1:0] src_hold;
    logic [N-1:0] fire_in;
    int           valid_pct;
    int           ready_pct;

    // reference model state: who owns the stream, and what the skid holds
    bit    m_held;
    int    m_grant;
    int    m_ptr;
    int    m_cnt;
    beat_t exp_q[$];
    beat_t out_log[$];
    int    out_cyc[$];
    int    frame_log[$];
    int    acc_by_chan[N];
    int    first_in_cyc;
    int    first_out_cyc;
    int    busy_gaps[$];
    int    low_run;
    bit    seen_busy;
    bit    prev_stall;
    beat_t prev_out;
    int    total_beats;

    always #5 clk = ~clk;

    fft_stream_arbiter #(
        .N         (N),
        .W         (W),
        .FRAME_LEN (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit all_src_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Reference model and per-cycle comparison, evaluated mid-cycle.
    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_ready;
        int           occ;
        int           c;
        bit           fout;
        beat_t        b;
        cyc++;
        if (!rst_n) begin
            m_held     = 1'b0;
            m_ptr      = N - 1;
            m_cnt      = 0;
            exp_q.delete();
            fire_in    = '0;
            prev_stall = 1'b0;
        end else begin
            occ       = exp_q.size();
            exp_ready = '0;
            if (m_held && occ < 2) exp_ready[m_grant] = 1'b1;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(m_held));
            check("out_valid", 32'(out_valid), 32'(occ > 0));
            if (occ > 0) begin
                check("out_data", 32'(out_data), 32'(exp_q[0].data));
                check("out_chan", 32'(out_chan), 32'(exp_q[0].chan));
                check("out_last", 32'(out_last), 32'(exp_q[0].last));
            end
            if (prev_stall) check("stall_hold", 32'({out_last, out_chan, out_data}), 32'(prev_out));
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_chan, out_data};

            if (first_in_cyc < 0 && |in_valid) first_in_cyc = cyc;
            if (first_out_cyc < 0 && out_valid) first_out_cyc = cyc;
            if (busy) begin
                if (seen_busy && low_run > 0) busy_gaps.push_back(low_run);
                seen_busy = 1'b1;
                low_run   = 0;
            end else if (seen_busy) begin
                low_run++;
            end

            fire_in = in_valid & exp_ready;
            fout    = (occ > 0) && out_ready;
            if (fout) begin
                b = exp_q.pop_front();
                out_log.push_back(b);
                out_cyc.push_back(cyc);
                if (b.last) frame_log.push_back(int'(b.chan));
            end
            if (m_held) begin
                if (fire_in[m_grant]) begin
                    m_cnt++;
                    b.data = in_data[m_grant*W +: W];
                    b.chan = CW'(m_grant);
                    b.last = in_last[m_grant] || (FLEN > 0 && m_cnt == FLEN);
                    exp_q.push_back(b);
                    acc_by_chan[m_grant]++;
                    if (b.last) begin
                        m_held = 1'b0;
                        m_ptr  = m_grant;
                    end
                end
            end else if (|in_valid) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (in_valid[c]) begin
                        m_grant = c;
                        break;
                    end
                end
                m_held = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    // Source and sink driver, just after each rising edge.
    initial begin
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst_n && fire_in[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            fire_in = '0;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0 && !src_hold[i] && int'($urandom_range(99)) < valid_pct) begin
                    in_valid[i]       = 1'b1;
                    in_data[i*W +: W] = src_q[i][0][W-1:0];
                    in_last[i]        = src_q[i][0][W];
                end else begin
                    in_valid[i]       = 1'b0;
                    in_data[i*W +: W] = W'($urandom);
                    in_last[i]        = 1'($urandom_range(1));
                end
            end
            out_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        src_hold = '0;
        fire_in  = '0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            acc_by_chan[i] = 0;
        end
        out_log.delete();
        out_cyc.delete();
        frame_log.delete();
        busy_gaps.delete();
        seen_busy     = 1'b0;
        low_run       = 0;
        first_in_cyc  = -1;
        first_out_cyc = -1;
        total_beats   = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic load_frame(input int ch, input int len, input int base, input bit with_last);
        for (int j = 0; j < len; j++) begin
            src_q[ch].push_back({with_last && (j == len - 1), 16'(base + j)});
            total_beats++;
        end
    endtask

    task automatic drain(input int maxc, input string name);
        int n = 0;
        while (!(all_src_empty() && exp_q.size() == 0) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required drained", name, maxc);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_acc(input int ch, input int cnt, input int maxc, input string name);
        int n = 0;
        while (acc_by_chan[ch] < cnt && n < maxc) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: accepted %0d, required %0d", name, acc_by_chan[ch], cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        src_hold  = '0;
        valid_pct = 100;
        ready_pct = 100;

        // 1: reset values, then a 3-beat frame on channel 0
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        load_frame(0, 1, 16'h0011, 1'b0);
        load_frame(0, 1, 16'h0022, 1'b0);
        load_frame(0, 1, 16'h0033, 1'b1);
        drain(100, "t1");
        check("t1_latency", 32'(first_out_cyc - first_in_cyc), 32'd2);
        check("t1_beats", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check("t1_d0", 32'(out_log[0]), 32'({1'b0, 2'd0, 16'h0011}));
            check("t1_d1", 32'(out_log[1]), 32'({1'b0, 2'd0, 16'h0022}));
            check("t1_d2", 32'(out_log[2]), 32'({1'b1, 2'd0, 16'h0033}));
            check("t1_back_to_back", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        end

        // 2: all four request together, 2-beat frames
        do_reset();
        for (int i = 0; i < N; i++) load_frame(i, 2, 16'h0100 * i, 1'b1);
        drain(200, "t2");
        check("t2_frames", 32'(frame_log.size()), 32'd4);
        if (frame_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t2_order", 32'(frame_log[i]), 32'(i));
        end
        check("t2_gaps", 32'(busy_gaps.size()), 32'd3);
        foreach (busy_gaps[i]) check("t2_gap_len", 32'(busy_gaps[i]), 32'd1);

        // 3: downstream stalled, channel 1 granted
        do_reset();
        ready_pct = 0;
        load_frame(1, 4, 16'h1000, 1'b1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        #2;
        check("t3_accepted", 32'(acc_by_chan[1]), 32'd2);
        check("t3_in_ready", 32'(in_ready), 32'h0);
        check("t3_out_valid", 32'(out_valid), 32'h1);
        check("t3_out_held", 32'(out_data), 32'h1000);
        ready_pct = 100;
        drain(100, "t3");
        check("t3_beats", 32'(out_log.size()), 32'd4);
        if (out_log.size() == 4) begin
            for (int j = 0; j < 4; j++) check("t3_order", 32'(out_log[j].data), 32'(16'h1000 + j));
        end

        // 4: granted channel 2 pauses mid-frame while channel 3 waits
        do_reset();
        load_frame(2, 4, 16'h2000, 1'b1);
        load_frame(3, 2, 16'h3000, 1'b1);
        wait_acc(2, 1, 50, "t4_first");
        src_hold[2] = 1'b1;
        repeat (5) @(posedge clk);
        check("t4_ch3_waited", 32'(acc_by_chan[3]), 32'd0);
        src_hold[2] = 1'b0;
        drain(100, "t4");
        check("t4_frames", 32'(frame_log.size()), 32'd2);
        if (frame_log.size() == 2) begin
            check("t4_first", 32'(frame_log[0]), 32'd2);
            check("t4_second", 32'(frame_log[1]), 32'd3);
        end

        // 5: asynchronous reset mid-frame, then channel 0 wins first again
        do_reset();
        load_frame(0, 6, 16'h5000, 1'b1);
        wait_acc(0, 2, 50, "t5_mid");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_async_out_valid", 32'(out_valid), 32'h0);
        check("t5_async_in_ready", 32'(in_ready), 32'h0);
        check("t5_async_busy", 32'(busy), 32'h0);
        do_reset();
        load_frame(1, 1, 16'h5100, 1'b1);
        load_frame(0, 1, 16'h5000, 1'b1);
        drain(100, "t5");
        check("t5_frames", 32'(frame_log.size()), 32'd2);
        if (frame_log.size() == 2) begin
            check("t5_first", 32'(frame_log[0]), 32'd0);
            check("t5_second", 32'(frame_log[1]), 32'd1);
        end

`ifdef FFT_ARB_FRAME_CNT_EN
        // 6: channel 0 streams 12 beats with no last; cap forces a release at 8
        do_reset();
        load_frame(0, 12, 16'h6000, 1'b0);
        wait_acc(0, 1, 50, "t6_start");
        load_frame(1, 2, 16'h6100, 1'b1);
        drain(200, "t6");
        check("t6_beats", 32'(out_log.size()), 32'd14);
        if (out_log.size() == 14) begin
            check("t6_beat8", 32'(out_log[7]), 32'({1'b1, 2'd0, 16'h6007}));
            check("t6_ch1_a", 32'(out_log[8]), 32'({1'b0, 2'd1, 16'h6100}));
            check("t6_ch1_b", 32'(out_log[9]), 32'({1'b1, 2'd1, 16'h6101}));
            check("t6_beat9", 32'(out_log[10]), 32'({1'b0, 2'd0, 16'h6008}));
            check("t6_beat12", 32'(out_log[13]), 32'({1'b0, 2'd0, 16'h600b}));
        end
`endif

        // 7: random frames, random valid gaps and backpressure
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            valid_pct = (pass == 0) ? 70 : 100;
            ready_pct = (pass == 0) ? 60 : 100;
            for (int f = 0; f < 40; f++) begin
                load_frame($urandom_range(N - 1), $urandom_range(5, 1), $urandom_range(16'hffff), 1'b1);
            end
            drain(5000, "random");
            check("random_beats", 32'(out_log.size()), 32'(total_beats));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
